// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clock divider controller.
package clk_div_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Configuration handshake between a requester (master) and the divider controller (slave).
interface clk_div_ctrl_if
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_en;
    logic             cfg_err;
    logic             busy;

    modport master (
        output cfg_valid, cfg_div, cfg_en,
        input  cfg_ready, cfg_err, busy
    );

    modport slave (
        input  cfg_valid, cfg_div, cfg_en,
        output cfg_ready, cfg_err, busy
    );

endinterface

// File: rtl/clk_div_phase.sv
// Phase counter: counts 0..plen-1 while running, toggles level on wrap; load forces a fresh low phase.
module clk_div_phase #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] plen,
    output logic             wrap,
    output logic             level
);

    logic [CNT_W-1:0] cnt;

    assign wrap = run && (cnt == plen - 1'b1);

    always_ff @(posedge clk_in) begin
        if (rst || load || !run) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (wrap) begin
            cnt   <= '0;
            level <= ~level;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Glitch-free clock divider with a handshake-driven reconfiguration FSM (STOP/RUN/PEND).
// Define CLK_DIV_CTRL_ODD_EN to accept odd divisors (high = (D-1)/2, low = (D+1)/2).
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DIV_RST = 2
) (
    input  logic           clk_in,
    input  logic           rst,
    clk_div_ctrl_if.slave  cfg,
    output logic           clk_out,
    output logic           tick
);

    state_e           state;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] pend_div;
    logic             pend_en;

    logic             hs, bad, take, run, apply, load;
    logic             wrap, level;
    logic [CNT_W-1:0] hi_len, lo_len, plen;

    assign cfg.cfg_ready = (state != PEND);
    assign cfg.busy      = (state == PEND);
    assign hs            = cfg.cfg_valid && cfg.cfg_ready;

`ifdef CLK_DIV_CTRL_ODD_EN
    assign bad    = (cfg.cfg_div < CNT_W'(2));
    assign hi_len = div_q >> 1;
    assign lo_len = div_q - (div_q >> 1);
`else
    assign bad    = (cfg.cfg_div < CNT_W'(2)) || cfg.cfg_div[0];
    assign hi_len = div_q >> 1;
    assign lo_len = hi_len;
`endif

    assign take  = hs && !bad;
    assign run   = (state != STOP);
    // Switch only at the end of a high phase so no output phase is ever truncated.
    assign apply = (state == PEND) && wrap && level;
    assign load  = apply || ((state == STOP) && take);
    assign plen  = level ? hi_len : lo_len;

    clk_div_phase #(.CNT_W(CNT_W)) u_phase (
        .clk_in (clk_in),
        .rst    (rst),
        .run    (run),
        .load   (load),
        .plen   (plen),
        .wrap   (wrap),
        .level  (level)
    );

    assign clk_out = level;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state       <= RUN;
            div_q       <= CNT_W'(DIV_RST);
            pend_div    <= '0;
            pend_en     <= 1'b0;
            cfg.cfg_err <= 1'b0;
            tick        <= 1'b0;
        end else begin
            cfg.cfg_err <= hs && bad;
            tick        <= wrap && !level;
            case (state)
                STOP: begin
                    if (take) begin
                        div_q <= cfg.cfg_div;
                        if (cfg.cfg_en) state <= RUN;
                    end
                end
                RUN: begin
                    if (take) begin
                        pend_div <= cfg.cfg_div;
                        pend_en  <= cfg.cfg_en;
                        state    <= PEND;
                    end
                end
                PEND: begin
                    if (apply) begin
                        div_q <= pend_div;
                        state <= pend_en ? RUN : STOP;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl (default DIV_RST = 2, CNT_W = 16).
module tb_clk_div_ctrl;
    import clk_div_pkg::*;

    logic clk_in = 1'b0;
    logic rst;
    logic clk_out, tick;
    int   total = 0;
    int   errs  = 0;

    clk_div_ctrl_if #(.CNT_W(16)) cfg ();

    clk_div_ctrl #(.CNT_W(16), .DIV_RST(2)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .cfg     (cfg),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic en);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_div   = d;
        cfg.cfg_en    = en;
        step();
        cfg.cfg_valid = 1'b0;
    endtask

    // Samples the current cycle, then advances; bit i = i-th sampled cycle.
    task automatic capture(input int n, output logic [31:0] c, output logic [31:0] t,
                           output logic [31:0] b);
        c = '0; t = '0; b = '0;
        for (int i = 0; i < n; i++) begin
            c[i] = clk_out;
            t[i] = tick;
            b[i] = cfg.busy;
            step();
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (cfg.busy !== 1'b0 && k < 40) begin step(); k++; end
        total++;
        if (cfg.busy !== 1'b0) begin errs++; $display("FAIL %s busy timeout got=%b want=0", name, cfg.busy); end
    endtask

    task automatic wait_tick(input string name);
        int k = 0;
        while (tick !== 1'b1 && k < 40) begin step(); k++; end
        total++;
        if (tick !== 1'b1) begin errs++; $display("FAIL %s tick timeout got=%b want=1", name, tick); end
    endtask

    task automatic test_reset();
        logic [31:0] c, t, b;
        rst = 1'b1;
        step(); step();
        total += 5;
        if (clk_out !== 1'b0)       begin errs++; $display("FAIL rst_clk got=%b want=0", clk_out); end
        if (tick !== 1'b0)          begin errs++; $display("FAIL rst_tick got=%b want=0", tick); end
        if (cfg.cfg_err !== 1'b0)   begin errs++; $display("FAIL rst_err got=%b want=0", cfg.cfg_err); end
        if (cfg.busy !== 1'b0)      begin errs++; $display("FAIL rst_busy got=%b want=0", cfg.busy); end
        if (cfg.cfg_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got=%b want=1", cfg.cfg_ready); end
        rst = 1'b0;
        step();
        capture(8, c, t, b);
        total += 3;
        if (c[7:0] !== 8'h55) begin errs++; $display("FAIL div2_clk got=%h want=55", c[7:0]); end
        if (t[7:0] !== 8'h55) begin errs++; $display("FAIL div2_tick got=%h want=55", t[7:0]); end
        if (cfg.cfg_ready !== 1'b1) begin errs++; $display("FAIL div2_ready got=%b want=1", cfg.cfg_ready); end
    endtask

    task automatic test_stop();
        logic [31:0] c, t, b;
        send(16'd6, 1'b0);
        capture(8, c, t, b);
        total += 5;
        if (c[7:0] !== 8'h02) begin errs++; $display("FAIL stop_clk got=%h want=02", c[7:0]); end
        if (t[7:0] !== 8'h02) begin errs++; $display("FAIL stop_tick got=%h want=02", t[7:0]); end
        if (b[7:0] !== 8'h03) begin errs++; $display("FAIL stop_busy got=%h want=03", b[7:0]); end
        if (dut.state !== STOP) begin errs++; $display("FAIL stop_state got=%0d want=%0d", dut.state, STOP); end
        if (dut.div_q !== 16'd6) begin errs++; $display("FAIL stop_div got=%0d want=6", dut.div_q); end
    endtask

    task automatic test_start();
        logic [31:0] c, t, b;
        send(16'd10, 1'b1);
        capture(12, c, t, b);
        total += 3;
        if (c[11:0] !== 12'h3E0) begin errs++; $display("FAIL start_clk got=%h want=3e0", c[11:0]); end
        if (t[11:0] !== 12'h020) begin errs++; $display("FAIL start_tick got=%h want=020", t[11:0]); end
        if (dut.state !== RUN)   begin errs++; $display("FAIL start_state got=%0d want=%0d", dut.state, RUN); end
    endtask

    task automatic test_switch();
        logic [31:0] c, t, b;
        send(16'd4, 1'b1);
        wait_idle("sw_setup");
        wait_tick("sw_setup");
        step(); step();
        total++;
        if (clk_out !== 1'b0) begin errs++; $display("FAIL sw_low got=%b want=0", clk_out); end
        send(16'd8, 1'b1);
        capture(12, c, t, b);
        total += 4;
        if (c[11:0] !== 12'h786) begin errs++; $display("FAIL sw_clk got=%h want=786", c[11:0]); end
        if (t[11:0] !== 12'h082) begin errs++; $display("FAIL sw_tick got=%h want=082", t[11:0]); end
        if (b[11:0] !== 12'h007) begin errs++; $display("FAIL sw_busy got=%h want=007", b[11:0]); end
        if (dut.div_q !== 16'd8) begin errs++; $display("FAIL sw_div got=%0d want=8", dut.div_q); end
    endtask

    task automatic test_reject();
        logic [31:0] c, t, b;
        logic [15:0] bad_div [2] = '{16'd1, 16'd0};
        foreach (bad_div[i]) begin
            send(bad_div[i], 1'b1);
            total += 3;
            if (cfg.cfg_err !== 1'b1) begin errs++; $display("FAIL rej%0d_err got=%b want=1", bad_div[i], cfg.cfg_err); end
            if (cfg.busy !== 1'b0)    begin errs++; $display("FAIL rej%0d_busy got=%b want=0", bad_div[i], cfg.busy); end
            if (dut.div_q !== 16'd8)  begin errs++; $display("FAIL rej%0d_div got=%0d want=8", bad_div[i], dut.div_q); end
            step();
            total++;
            if (cfg.cfg_err !== 1'b0) begin errs++; $display("FAIL rej%0d_pulse got=%b want=0", bad_div[i], cfg.cfg_err); end
        end
        send(16'd5, 1'b1);
`ifdef CLK_DIV_CTRL_ODD_EN
        total++;
        if (cfg.cfg_err !== 1'b0) begin errs++; $display("FAIL odd_err got=%b want=0", cfg.cfg_err); end
        wait_idle("odd");
        wait_tick("odd");
        capture(6, c, t, b);
        total++;
        if (c[5:0] !== 6'h23) begin errs++; $display("FAIL odd_clk got=%h want=23", c[5:0]); end
`else
        total += 3;
        if (cfg.cfg_err !== 1'b1) begin errs++; $display("FAIL odd_err got=%b want=1", cfg.cfg_err); end
        if (dut.div_q !== 16'd8)  begin errs++; $display("FAIL odd_div got=%0d want=8", dut.div_q); end
        if (dut.state !== RUN)    begin errs++; $display("FAIL odd_state got=%0d want=%0d", dut.state, RUN); end
        capture(2, c, t, b);
        total++;
        if (cfg.cfg_err !== 1'b0) begin errs++; $display("FAIL odd_pulse got=%b want=0", cfg.cfg_err); end
`endif
    endtask

    task automatic test_pend();
        int k = 0;
        cfg.cfg_valid = 1'b1;
        cfg.cfg_div   = 16'd6;
        cfg.cfg_en    = 1'b1;
        step();
        cfg.cfg_div = 16'd12;
        total++;
        if (cfg.busy !== 1'b1) begin errs++; $display("FAIL pend_busy got=%b want=1", cfg.busy); end
        while (cfg.busy === 1'b1 && k < 40) begin
            total += 2;
            if (cfg.cfg_ready !== 1'b0) begin errs++; $display("FAIL pend_ready got=%b want=0", cfg.cfg_ready); end
            if (dut.pend_div !== 16'd6) begin errs++; $display("FAIL pend_cap got=%0d want=6", dut.pend_div); end
            step();
            k++;
        end
        cfg.cfg_valid = 1'b0;
        total += 2;
        if (cfg.busy !== 1'b0)   begin errs++; $display("FAIL pend_timeout got=%b want=0", cfg.busy); end
        if (dut.div_q !== 16'd6) begin errs++; $display("FAIL pend_div got=%0d want=6", dut.div_q); end

        send(16'd10, 1'b1);
        total++;
        if (cfg.busy !== 1'b1) begin errs++; $display("FAIL pend2_busy got=%b want=1", cfg.busy); end
        rst = 1'b1;
        cfg.cfg_valid = 1'b1;
        cfg.cfg_div   = 16'd4;
        cfg.cfg_en    = 1'b0;
        step();
        total += 4;
        if (dut.state !== RUN)   begin errs++; $display("FAIL prst_state got=%0d want=%0d", dut.state, RUN); end
        if (dut.div_q !== 16'd2) begin errs++; $display("FAIL prst_div got=%0d want=2", dut.div_q); end
        if (clk_out !== 1'b0)    begin errs++; $display("FAIL prst_clk got=%b want=0", clk_out); end
        if (cfg.busy !== 1'b0)   begin errs++; $display("FAIL prst_busy got=%b want=0", cfg.busy); end
        step();
        total += 2;
        if (cfg.busy !== 1'b0)   begin errs++; $display("FAIL rst_prio_busy got=%b want=0", cfg.busy); end
        if (dut.div_q !== 16'd2) begin errs++; $display("FAIL rst_prio_div got=%0d want=2", dut.div_q); end
        rst = 1'b0;
        cfg.cfg_valid = 1'b0;
        step();
        total += 2;
        if (clk_out !== 1'b1) begin errs++; $display("FAIL post_rst_clk got=%b want=1", clk_out); end
        if (tick !== 1'b1)    begin errs++; $display("FAIL post_rst_tick got=%b want=1", tick); end
        step();
        total++;
        if (clk_out !== 1'b0) begin errs++; $display("FAIL post_rst_low got=%b want=0", clk_out); end
    endtask

    initial begin
        rst           = 1'b1;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_div   = '0;
        cfg.cfg_en    = 1'b0;
        test_reset();
        test_stop();
        test_start();
        test_switch();
        test_reject();
        test_pend();
        $display("test done: total=%0d bad=%0d", total, errs);
        $finish;
    end

endmodule
